// File: rtl/fp_as_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_as_scheduler_if
// Brief    : Requester-side bus of the shared fp_add_sub scheduler.
// Revision : 1.0
// ============================================================================
interface fp_as_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/fp_as_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fp_as_scheduler
// Brief    : Round-robin sharing of one fp_add_sub unit among NREQ requesters.
// Revision : 1.0
// ============================================================================
module fp_as_scheduler #(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fp_as_scheduler_if.slave bus,
    output logic             fpu_signal,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  wire logic [31:0] fpu_out,
    output logic             busy
);
    localparam int c_IDW   = $clog2(NREQ);
    // Stage 0 shadows the operand register; the remaining LAT stages track fp_add_sub.
    localparam int c_DEPTH = LAT + 1;

    logic [c_IDW-1:0]   r_rr_ptr;
    logic [NREQ-1:0]    r_pending;
    logic [c_DEPTH-1:0] r_tag_v;
    logic [c_IDW-1:0]   r_tag_id [c_DEPTH];
    logic [31:0]        r_fpu_a;
    logic [31:0]        r_fpu_b;
    logic               r_fpu_signal;

    logic [NREQ-1:0]    w_elig;
    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_retire;
    logic [c_IDW-1:0]   w_win;
    logic [c_IDW-1:0]   w_idx;
    logic [c_IDW-1:0]   w_ptr_next;
    logic               w_found;
    int                 w_sum;

    assign w_elig = bus.req_valid & ~r_pending;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_idx = c_IDW'(w_sum);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found && !rst) begin
            w_grant[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_retire = '0;
        if (r_tag_v[c_DEPTH-1]) begin
            w_retire[r_tag_id[c_DEPTH-1]] = 1'b1;
        end
    end

    assign w_ptr_next = (w_win == c_IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_pending    <= '0;
            r_tag_v      <= '0;
            r_fpu_a      <= '0;
            r_fpu_b      <= '0;
            r_fpu_signal <= 1'b0;
            for (int s = 0; s < c_DEPTH; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_pending   <= (r_pending & ~w_retire) | w_grant;
            r_tag_v     <= {r_tag_v[c_DEPTH-2:0], w_found};
            r_tag_id[0] <= w_win;
            for (int s = 1; s < c_DEPTH; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            if (w_found) begin
                r_fpu_a      <= bus.req_a[32*int'(w_win) +: 32];
                r_fpu_b      <= bus.req_b[32*int'(w_win) +: 32];
                r_fpu_signal <= bus.req_op[w_win];
                r_rr_ptr     <= w_ptr_next;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = w_retire;
    assign bus.rsp_data  = fpu_out;
    assign fpu_a         = r_fpu_a;
    assign fpu_b         = r_fpu_b;
    assign fpu_signal    = r_fpu_signal;
    assign busy          = |r_pending;

endmodule
`default_nettype wire
